led_channel_driver: RTL and testbench

//   Multi-channel LED driver; successor to the single fixed-rate heartbeat toggle.

---
 rtl/led_channel_driver.sv | 133 +++++++++++++
 tb/tb_led_channel_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_channel_driver.sv
// led_channel_driver: shared tick prescaler and free-running PWM counter feeding
// CHANNELS independent LED outputs, each in OFF, ON, BLINK or PWM mode. Modes are
// written at run time through a valid/ready config port.
module led_channel_driver #(
   parameter int CHANNELS     = 4,
   parameter int CLK_FREQ     = 50000000,
   parameter int TICK_FREQ    = 1000,
   parameter int VALUE_WIDTH  = 16,
   parameter int PWM_WIDTH    = 8,
   parameter int RESET_BLINK  = 1,
   parameter int RESET_PERIOD = 1000,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CH_W-1:0]        cfg_channel,
   input  logic [1:0]             cfg_mode,
   input  logic [VALUE_WIDTH-1:0] cfg_value,
   output logic                   tick,
   output logic [CHANNELS-1:0]    led
);

   localparam int DIV = CLK_FREQ / TICK_FREQ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_PWM   = 2'd3;

   logic [PW-1:0]        pre_cnt;
   logic [PWM_WIDTH-1:0] pwm_cnt;
   logic                 accept;
   logic [CHANNELS-1:0]  drive;
   logic [CHANNELS-1:0]  drive_q;

   assign accept = cfg_valid & cfg_ready;

   // Prescaler: wraps every DIV clocks; tick is high for the cycle after the wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (pre_cnt == PRE_MAX) begin
         pre_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   // Shared free-running PWM counter, untouched by config writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pwm_cnt <= '0;
      else       pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Config port becomes ready one edge after reset release and stays ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cfg_ready <= 1'b0;
      else       cfg_ready <= 1'b1;
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(g);
      localparam bit RST_BLINK = (g == 0) && (RESET_BLINK != 0);
      localparam logic [1:0] RST_MODE = RST_BLINK ? MODE_BLINK : MODE_OFF;
      localparam logic [VALUE_WIDTH-1:0] RST_VAL =
         RST_BLINK ? VALUE_WIDTH'(RESET_PERIOD) : '0;

      logic [1:0]             mode;
      logic [VALUE_WIDTH-1:0] value;
      logic [VALUE_WIDTH-1:0] blink_cnt;
      logic [VALUE_WIDTH-1:0] last_cnt;
      logic                   phase;
      logic                   wr;

      assign wr       = accept && (cfg_channel == IDX);
      // A half-period of 0 behaves as 1: toggle on every tick.
      assign last_cnt = (value == '0) ? '0 : value - VALUE_WIDTH'(1);

      // Mode/value register and blink timer; a write beats a coincident tick.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            mode      <= RST_MODE;
            value     <= RST_VAL;
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (wr) begin
            mode      <= cfg_mode;
            value     <= cfg_value;
            blink_cnt <= '0;
            phase     <= 1'b0;
         end else if (mode == MODE_BLINK && tick) begin
            if (blink_cnt == last_cnt) begin
               blink_cnt <= '0;
               phase     <= ~phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
      end

      // Per-channel drive level selected by mode.
      always_comb begin
         drive[g] = 1'b0;
         case (mode)
            MODE_OFF:   drive[g] = 1'b0;
            MODE_ON:    drive[g] = 1'b1;
            MODE_BLINK: drive[g] = phase;
            MODE_PWM:   drive[g] = (pwm_cnt < value[PWM_WIDTH-1:0]);
            default:    drive[g] = 1'b0;
         endcase
      end
   end

   // Two register stages from mode state to the pins: a new mode shows on led
   // two edges after the accepting edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drive_q <= '0;
         led     <= '0;
      end else begin
         drive_q <= drive;
         led     <= drive_q;
      end
   end

endmodule

// File: tb/tb_led_channel_driver.sv
// Bench for led_channel_driver: expected led/tick/ready values are queued against
// an edge count since reset release; a negedge monitor pops and compares them.
module tb_led_channel_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_channel = '0;
   logic [1:0] cfg_mode = '0;
   logic [15:0] cfg_value = '0;
   logic       tick;
   logic [3:0] led;

   logic       d_valid = 1'b0;
   logic       d_ready;
   logic [1:0] d_channel = '0;
   logic [1:0] d_mode = '0;
   logic [15:0] d_value = '0;
   logic       d_tick;
   logic [2:0] d_led;

   int checks = 0;
   int errors = 0;
   int ecnt = 0;

   typedef struct {
      int         cyc;
      logic [3:0] lmask;
      logic [3:0] lexp;
      bit         ct;
      logic       tk;
      bit         cr;
      logic       rd;
      bit         cd;
      logic [2:0] dexp;
      string      name;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   led_channel_driver #(
      .CHANNELS(4), .CLK_FREQ(100), .TICK_FREQ(10), .VALUE_WIDTH(16),
      .PWM_WIDTH(8), .RESET_BLINK(1), .RESET_PERIOD(3)
   ) u_dut (
      .clk(clk), .reset(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_channel(cfg_channel), .cfg_mode(cfg_mode), .cfg_value(cfg_value),
      .tick(tick), .led(led)
   );

   led_channel_driver #(
      .CHANNELS(3), .CLK_FREQ(100), .TICK_FREQ(10), .VALUE_WIDTH(16),
      .PWM_WIDTH(8), .RESET_BLINK(0), .RESET_PERIOD(3)
   ) u_drop (
      .clk(clk), .reset(rst), .cfg_valid(d_valid), .cfg_ready(d_ready),
      .cfg_channel(d_channel), .cfg_mode(d_mode), .cfg_value(d_value),
      .tick(d_tick), .led(d_led)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, expv, ecnt);
      end
   endtask

   function automatic void push(input exp_t e);
      int i = 0;
      while (i < sbq.size() && sbq[i].cyc <= e.cyc) i++;
      sbq.insert(i, e);
   endfunction

   function automatic void exp_led(input int c, input logic [3:0] m, input logic [3:0] v,
                                   input string n);
      exp_t e = '{cyc: c, lmask: m, lexp: v, ct: 0, tk: 0, cr: 0, rd: 0, cd: 0,
                  dexp: 0, name: n};
      push(e);
   endfunction

   function automatic void exp_tick(input int c, input logic v, input string n);
      exp_t e = '{cyc: c, lmask: 0, lexp: 0, ct: 1, tk: v, cr: 0, rd: 0, cd: 0,
                  dexp: 0, name: n};
      push(e);
   endfunction

   function automatic void exp_rdy(input int c, input string n);
      exp_t e = '{cyc: c, lmask: 0, lexp: 0, ct: 0, tk: 0, cr: 1, rd: 1, cd: 0,
                  dexp: 0, name: n};
      push(e);
   endfunction

   function automatic void exp_dled(input int c, input logic [2:0] v, input string n);
      exp_t e = '{cyc: c, lmask: 0, lexp: 0, ct: 0, tk: 0, cr: 0, rd: 0, cd: 1,
                  dexp: v, name: n};
      push(e);
   endfunction

   // Monitor: compare every expectation that falls due at this edge count.
   always @(negedge clk) begin
      while (!rst && sbq.size() > 0 && sbq[0].cyc <= ecnt) begin
         mon_e = sbq.pop_front();
         if (mon_e.cyc < ecnt) begin
            checks++;
            errors++;
            $display("FAIL %s missed: due edge %0d, now %0d", mon_e.name, mon_e.cyc, ecnt);
         end else begin
            if (mon_e.lmask != 0)
               cmp({mon_e.name, "_led"}, 32'(led & mon_e.lmask), 32'(mon_e.lexp & mon_e.lmask));
            if (mon_e.ct) cmp({mon_e.name, "_tick"}, 32'(tick), 32'(mon_e.tk));
            if (mon_e.cr) begin
               cmp({mon_e.name, "_ready"}, 32'(cfg_ready), 32'(mon_e.rd));
               cmp({mon_e.name, "_dready"}, 32'(d_ready), 32'(mon_e.rd));
            end
            if (mon_e.cd) cmp({mon_e.name, "_dled"}, 32'(d_led), 32'(mon_e.dexp));
         end
      end
   end

   task automatic wait_edge(input int at);
      int guard = 0;
      while (ecnt < at && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (ecnt != at) begin
         checks++;
         errors++;
         $display("FAIL wait_edge actual=%0d expected=%0d", ecnt, at);
      end
   endtask

   // Drive one write at the negedge of edge 'at'; it is accepted on edge at+1.
   task automatic do_write(input bit drop, input int at, input logic [1:0] ch,
                           input logic [1:0] md, input logic [15:0] v);
      wait_edge(at);
      if (drop) begin
         d_valid = 1'b1; d_channel = ch; d_mode = md; d_value = v;
      end else begin
         cfg_valid = 1'b1; cfg_channel = ch; cfg_mode = md; cfg_value = v;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      d_valid = 1'b0;
   endtask

   task automatic count_led(input int from, input int n, input int b, input int expv,
                            input string name);
      int cnt = 0;
      wait_edge(from);
      for (int i = 0; i < n; i++) begin
         cnt += int'(led[b]);
         if (i < n - 1) @(negedge clk);
      end
      cmp(name, 32'(cnt), 32'(expv));
   endtask

   // Tick every 10 clks; ch0 BLINK with half-period 3 ticks shows on led at 33, 63, ...
   task automatic push_reset_timing(input string tag);
      exp_rdy(1, {tag, "_rdy1"});
      exp_led(1, 4'hF, 4'h0, {tag, "_led1"});
      exp_tick(9, 1'b0, {tag, "_tick9"});
      exp_tick(10, 1'b1, {tag, "_tick10"});
      exp_tick(11, 1'b0, {tag, "_tick11"});
      exp_tick(20, 1'b1, {tag, "_tick20"});
      exp_led(32, 4'hF, 4'h0, {tag, "_led32"});
      exp_led(33, 4'hF, 4'h1, {tag, "_led33"});
      exp_led(62, 4'hF, 4'h1, {tag, "_led62"});
      exp_led(63, 4'hF, 4'h0, {tag, "_led63"});
   endtask

   task automatic drain(input int budget);
      int guard = 0;
      while (sbq.size() > 0 && guard < budget) begin
         @(negedge clk);
         guard++;
      end
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain actual=%0d pending expected=0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state while held
      #12;
      cmp("rst_led", 32'(led), 32'h0);
      cmp("rst_tick", 32'(tick), 32'h0);
      cmp("rst_ready", 32'(cfg_ready), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1: reset-release timing
      push_reset_timing("t1");
      exp_dled(40, 3'b000, "t1_drop_off");

      // 2: ch1 ON then OFF
      exp_led(72, 4'h2, 4'h0, "t2_on_e1");
      exp_led(73, 4'hF, 4'h2, "t2_on_e2");
      do_write(0, 70, 2'd1, 2'd1, 16'd0);
      exp_led(82, 4'hF, 4'h2, "t2_off_e1");
      exp_led(83, 4'hF, 4'h0, "t2_off_e2");
      exp_led(93, 4'hF, 4'h1, "t2_others");
      do_write(0, 80, 2'd1, 2'd0, 16'd0);

      // 3: ch2 PWM duty 64, then duty 0
      exp_led(257, 4'h4, 4'h0, "t3_pwm257");
      exp_led(258, 4'h4, 4'h4, "t3_pwm258");
      exp_led(321, 4'h4, 4'h4, "t3_pwm321");
      exp_led(322, 4'h4, 4'h0, "t3_pwm322");
      do_write(0, 100, 2'd2, 2'd3, 16'd64);
      count_led(300, 256, 2, 64, "t3_pwm_high_count");
      do_write(0, 600, 2'd2, 2'd3, 16'd0);
      count_led(603, 512, 2, 0, "t3_pwm_zero_count");

      // 4: ch3 BLINK value 0 toggles every tick; out-of-range channel dropped
      exp_led(1212, 4'h8, 4'h0, "t4_b0_1212");
      exp_led(1213, 4'h8, 4'h8, "t4_b0_1213");
      exp_led(1222, 4'h8, 4'h8, "t4_b0_1222");
      exp_led(1223, 4'h8, 4'h0, "t4_b0_1223");
      do_write(0, 1203, 2'd3, 2'd2, 16'd0);
      exp_dled(1253, 3'b000, "t4_drop_1253");
      exp_dled(1260, 3'b000, "t4_drop_1260");
      do_write(1, 1250, 2'd3, 2'd1, 16'd0);
      exp_dled(1263, 3'b100, "t4_valid_1263");
      do_write(1, 1260, 2'd2, 2'd1, 16'd0);

      // 5: ch0 BLINK value 2 written on a tick cycle
      exp_led(1302, 4'hF, 4'h9, "t5_pre");
      exp_led(1303, 4'hF, 4'h0, "t5_clear");
      exp_led(1313, 4'h1, 4'h0, "t5_no_count");
      exp_led(1322, 4'h1, 4'h0, "t5_1322");
      exp_led(1323, 4'h1, 4'h1, "t5_toggle");
      exp_led(1330, 4'hF, 4'h1, "t5_1330");
      exp_tick(1330, 1'b1, "t5_tick1330");
      wait_edge(1299);
      cmp("t5_tick_before_write", 32'(tick), 32'h0);
      do_write(0, 1300, 2'd0, 2'd2, 16'd2);
      wait_edge(1330);
      drain(20);

      // 6: async reset mid-blink, then reset timing repeats
      #3;
      rst = 1'b1;
      #1;
      cmp("t6_async_led", 32'(led), 32'h0);
      cmp("t6_async_tick", 32'(tick), 32'h0);
      cmp("t6_async_ready", 32'(cfg_ready), 32'h0);
      cmp("t6_async_dled", 32'(d_led), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      push_reset_timing("t6");
      exp_led(73, 4'hE, 4'h0, "t6_cfg_default");
      wait_edge(75);
      drain(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
